quad_encoder_gen: RTL and testbench

- Generates quadrature encoder signals (qa, qb, idx) from a commanded burst: N edges, direction, edge spacing in clocks.
- It is the transmit-side counterpart of the motor encoder tick counter, which counts rising edges of channel A.
- Used for hardware-in-loop and bench stimulus of the SPWM/motor-control path without a physical motor.
- Also reports the A-rising-edge count it has emitted, so a downstream tick counter can be checked against it.

---
 rtl/quad_encoder_gen_pkg.sv | 33 +++
 rtl/quad_encoder_gen_if.sv | 22 ++
 rtl/quad_encoder_gen_edge_timer.sv | 38 +++
 rtl/quad_encoder_gen.sv | 146 ++++++++++++++
 tb/tb_quad_encoder_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// Shared definitions for the quadrature encoder generator: FSM states,
// next-phase lookup constants and the default tick-count width.
package quad_encoder_gen_pkg;

    localparam int DEFAULT_TICK_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Next {qa,qb} indexed by the current {qa,qb}; slice [2*p+1:2*p] holds next(p).
    // Forward walks 00->10->11->01->00 (A leads B).
    localparam logic [7:0] FWD_NEXT_LUT = {2'b01, 2'b11, 2'b00, 2'b10};
    // Reverse walks 00->01->11->10->00 (B leads A).
    localparam logic [7:0] REV_NEXT_LUT = {2'b10, 2'b00, 2'b11, 2'b01};

    // One quadrature step from the current phase; exactly one bit changes.
    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
        logic [1:0] nxt;
        nxt = 2'b00;
        case (phase)
            2'b00:   nxt = dir ? REV_NEXT_LUT[1:0] : FWD_NEXT_LUT[1:0];
            2'b01:   nxt = dir ? REV_NEXT_LUT[3:2] : FWD_NEXT_LUT[3:2];
            2'b10:   nxt = dir ? REV_NEXT_LUT[5:4] : FWD_NEXT_LUT[5:4];
            2'b11:   nxt = dir ? REV_NEXT_LUT[7:6] : FWD_NEXT_LUT[7:6];
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Burst command channel of the quadrature encoder generator.
interface quad_encoder_gen_if #(
    parameter int EDGE_W = 16,
    parameter int PER_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [EDGE_W-1:0] cmd_edges;
    logic              cmd_dir;
    logic [PER_W-1:0]  cmd_period;
    logic              abort;

    modport master (
        output cmd_valid, cmd_edges, cmd_dir, cmd_period, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_edges, cmd_dir, cmd_period, abort,
        output cmd_ready
    );
endinterface

// File: rtl/quad_encoder_gen_edge_timer.sv
// Edge spacing timer: holds the effective period of the current burst and
// raises a one-cycle step strobe every period clocks while running.
module quad_encoder_gen_edge_timer #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PER_W-1:0] period,
    input  logic             run,
    input  logic             abort,
    output logic             step
);

    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1'b1);

    logic [PER_W-1:0] timer_r;
    logic [PER_W-1:0] period_r;

    // Step fires on the last clock of each period; an abort on that clock wins.
    assign step = run && !abort && (timer_r == (period_r - PER_ONE));

    // Period latch and free-running count, cleared on load, abort, step or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r  <= {PER_W{1'b0}};
            period_r <= PER_ONE;
        end else if (load) begin
            timer_r  <= {PER_W{1'b0}};
            period_r <= period;
        end else if (!run || abort || step) begin
            timer_r  <= {PER_W{1'b0}};
        end else begin
            timer_r  <= timer_r + PER_ONE;
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: emits a commanded burst of qa/qb edges with
// a programmable spacing, an index pulse once per revolution and a running
// count of qa rising edges for checking a downstream tick counter.
module quad_encoder_gen
    import quad_encoder_gen_pkg::*;
#(
    parameter int TICK_W = DEFAULT_TICK_W,
    parameter int EDGE_W = 16,
    parameter int PER_W  = 16,
    parameter int CPR    = 256
) (
    input  logic              clk,
    input  logic              rst,
    quad_encoder_gen_if.slave cmd,
    output logic              qa,
    output logic              qb,
    output logic              idx,
    output logic [TICK_W-1:0] ticks,
    output logic              busy,
    output logic              done
);

    localparam int               REV_W    = $clog2(CPR);
    localparam logic [REV_W-1:0] REV_LAST = REV_W'(CPR - 1);
    localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1'b1);

    state_t            state_r;
    logic [1:0]        phase_r;
    logic              dir_r;
    logic [EDGE_W-1:0] remain_r;
    logic [TICK_W-1:0] ticks_r;
    logic [REV_W-1:0]  rev_cnt_r;
    logic              idx_r;
    logic              busy_r;
    logic              done_r;
    logic              ready_r;

    logic              accept_s;
    logic              load_s;
    logic [PER_W-1:0]  per_eff_s;
    logic              run_s;
    logic              step_s;
    logic [1:0]        nxt_phase_s;
    logic              qa_rise_s;

    // ready_r is high exactly while in IDLE, so it doubles as the accept gate.
    assign accept_s    = cmd.cmd_valid && ready_r;
    assign load_s      = accept_s && (cmd.cmd_edges != {EDGE_W{1'b0}});
    assign per_eff_s   = (cmd.cmd_period == {PER_W{1'b0}}) ? PER_ONE : cmd.cmd_period;
    assign run_s       = (state_r == RUN);
    assign nxt_phase_s = next_phase(phase_r, dir_r);
    assign qa_rise_s   = !phase_r[1] && nxt_phase_s[1];

    assign cmd.cmd_ready = ready_r;
    assign qa            = phase_r[1];
    assign qb            = phase_r[0];
    assign idx           = idx_r;
    assign ticks         = ticks_r;
    assign busy          = busy_r;
    assign done          = done_r;

    quad_encoder_gen_edge_timer #(
        .PER_W (PER_W)
    ) u_edge_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .period (per_eff_s),
        .run    (run_s),
        .abort  (cmd.abort),
        .step   (step_s)
    );

    // Burst FSM with phase register, emitted tick count, revolution counter and index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            phase_r   <= 2'b00;
            dir_r     <= 1'b0;
            remain_r  <= {EDGE_W{1'b0}};
            ticks_r   <= {TICK_W{1'b0}};
            rev_cnt_r <= {REV_W{1'b0}};
            idx_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dir_r    <= cmd.cmd_dir;
                        remain_r <= cmd.cmd_edges;
                        ready_r  <= 1'b0;
                        if (cmd.cmd_edges == {EDGE_W{1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cmd.abort) begin
                        // Levels and index hold; no completion pulse on abort.
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else if (step_s) begin
                        phase_r  <= nxt_phase_s;
                        remain_r <= remain_r - EDGE_W'(1'b1);
                        if (qa_rise_s) begin
                            ticks_r <= ticks_r + TICK_W'(1'b1);
                            if (rev_cnt_r == REV_LAST) begin
                                rev_cnt_r <= {REV_W{1'b0}};
                                idx_r     <= 1'b1;
                            end else begin
                                rev_cnt_r <= rev_cnt_r + REV_W'(1'b1);
                                idx_r     <= 1'b0;
                            end
                        end else begin
                            idx_r <= 1'b0;
                        end
                        if (remain_r == EDGE_W'(1'b1)) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: table of directed bursts,
// reset/index/wrap sequences and randomized bursts against a position model.
module tb_quad_encoder_gen;

    localparam int TICK_W = 10;
    localparam int EDGE_W = 16;
    localparam int PER_W  = 16;
    localparam int CPR    = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              qa, qb, idx, busy, done;
    logic [TICK_W-1:0] ticks;

    quad_encoder_gen_if #(.EDGE_W(EDGE_W), .PER_W(PER_W)) bus ();

    quad_encoder_gen #(
        .TICK_W (TICK_W),
        .EDGE_W (EDGE_W),
        .PER_W  (PER_W),
        .CPR    (CPR)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (bus),
        .qa    (qa),
        .qb    (qb),
        .idx   (idx),
        .ticks (ticks),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: position on the quadrature cycle and total A rises.
    int m_pos   = 0;
    int m_rises = 0;
    bit m_idx   = 1'b0;
    int idx_hi  = 0;

    // Downstream tick counter observing qa only.
    int   dn_rises = 0;
    logic qa_q     = 1'b0;

    always @(negedge clk) begin
        if (qa === 1'b1 && qa_q === 1'b0) dn_rises++;
        qa_q = qa;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endfunction

    // Position 0..3 on the cycle 00,10,11,01 as {qa,qb}.
    function automatic logic [1:0] gray(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic void model_step(input bit dir);
        logic [1:0] old_ph, new_ph;
        old_ph = gray(m_pos);
        m_pos  = dir ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
        new_ph = gray(m_pos);
        if (!old_ph[1] && new_ph[1]) begin
            m_rises++;
            m_idx = ((m_rises % CPR) == 0);
        end else begin
            m_idx = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_pos   = 0;
        m_rises = 0;
        m_idx   = 1'b0;
    endfunction

    // Issue one burst at the current negedge and check every cycle until idle.
    // ab >= 1 raises abort so that it is sampled ab clocks after the accept edge.
    task automatic run_burst(input int n, input bit dir, input int per, input int ab);
        int eff, span, t_end, te, steps, m_steps;
        bit aborted;
        eff  = (per == 0) ? 1 : per;
        span = n * eff;
        chk("ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_edges  = EDGE_W'(n);
        bus.cmd_dir    = dir;
        bus.cmd_period = PER_W'(per);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        t_end = span + 1;
        if (ab >= 1 && ab + eff + 2 > t_end) t_end = ab + eff + 2;
        m_steps = 0;
        for (int t = 0; t <= t_end; t++) begin
            aborted = (ab >= 1) && (ab <= span) && (t >= ab);
            te      = aborted ? ab - 1 : t;
            steps   = te / eff;
            if (steps > n) steps = n;
            while (m_steps < steps) begin
                model_step(dir);
                m_steps++;
            end
            chk("qa", qa, gray(m_pos) >> 1);
            chk("qb", qb, gray(m_pos) & 2'b01);
            chk("busy", busy, (!aborted && t < span) ? 1 : 0);
            chk("done", done, (!aborted && t == span) ? 1 : 0);
            chk("cmd_ready", bus.cmd_ready, (aborted || t > span) ? 1 : 0);
            chk("ticks", ticks, m_rises % (1 << TICK_W));
            chk("idx", idx, m_idx);
            if (idx === 1'b1) idx_hi++;
            bus.abort = (ab >= 1 && t == ab - 1) ? 1'b1 : 1'b0;
            if (t < t_end) @(negedge clk);
        end
        bus.abort = 1'b0;
    endtask

    typedef struct {
        int         edges;
        bit         dir;
        int         period;
        int         ab;
        logic [1:0] exp_ab;
        int         exp_ticks;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int   dn0, tk0, n, p, eff, ab;
        bit   d, found;

        tbl[0] = '{8,   1'b0, 4,  -1, 2'b00, 2};  // forward, spacing 4
        tbl[1] = '{4,   1'b1, 1,  -1, 2'b00, 3};  // reverse chained, one A rise at 01->11
        tbl[2] = '{0,   1'b0, 7,  -1, 2'b00, 3};  // zero edges
        tbl[3] = '{3,   1'b0, 0,  -1, 2'b01, 4};  // period 0 acts as 1
        tbl[4] = '{3,   1'b0, 1,  -1, 2'b11, 5};  // same burst with period 1
        tbl[5] = '{2,   1'b1, 3,  -1, 2'b00, 5};  // reverse from 11
        tbl[6] = '{100, 1'b0, 10, 55, 2'b10, 7};  // abort after 5 steps

        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_edges  = {EDGE_W{1'b0}};
        bus.cmd_dir    = 1'b0;
        bus.cmd_period = {PER_W{1'b0}};
        bus.abort      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_qa", qa, 0);
        chk("rst_qb", qb, 0);
        chk("rst_idx", idx, 0);
        chk("rst_ticks", ticks, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        model_reset();

        for (int i = 0; i < 7; i++) begin
            dn0 = dn_rises;
            tk0 = int'(ticks);
            run_burst(tbl[i].edges, tbl[i].dir, tbl[i].period, tbl[i].ab);
            chk("tbl_phase", {qa, qb}, tbl[i].exp_ab);
            chk("tbl_ticks", ticks, tbl[i].exp_ticks);
            chk("dn_vs_ticks", (dn_rises - dn0) % (1 << TICK_W),
                (int'(ticks) - tk0 + (1 << TICK_W)) % (1 << TICK_W));
        end

        // Reset in the middle of a burst while {qa,qb}=11, with a command pending.
        bus.cmd_valid  = 1'b1;
        bus.cmd_edges  = EDGE_W'(20);
        bus.cmd_dir    = 1'b0;
        bus.cmd_period = PER_W'(3);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if ({qa, qb} === 2'b11) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_reached_11", found, 1);
        chk("rst_mid_busy_before", busy, 1);
        rst            = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_edges  = EDGE_W'(5);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_qa", qa, 0);
        chk("rst_mid_qb", qb, 0);
        chk("rst_mid_ticks", ticks, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_ready", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_no_accept", busy, 0);
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_release_busy", busy, 0);
        chk("rst_release_ready", bus.cmd_ready, 1);
        model_reset();

        // 4096 forward edges: four index pulses and a tick wrap to 0.
        idx_hi = 0;
        for (int i = 0; i < 4; i++) run_burst(1024, 1'b0, 1, -1);
        chk("idx_pulse_cycles", idx_hi, 4);
        chk("ticks_wrap", ticks, 0);

        // Randomized bursts, some with an abort.
        for (int i = 0; i < 30; i++) begin
            n   = int'($urandom_range(0, 12));
            d   = 1'($urandom_range(0, 1));
            p   = int'($urandom_range(0, 4));
            eff = (p == 0) ? 1 : p;
            ab  = -1;
            if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, n * eff + 2));
            run_burst(n, d, p, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

endmodule
